serial_word_collector: RTL

- Serial-to-parallel receiver: the opposite end of the team's parallel-load, shift-right serializer.
- Accepts one bit per qualified cycle, LSB first, and assembles an N-bit word.
- Presents each completed word on a registered valid/ready output with a one-word holding buffer, so collection of the next word continues while the current word waits.
- Sits between any LSB-first serial source (e.g. the serializer's data_out[0]) and a parallel consumer.

---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_word_collector_word_holding_reg.sv | 51 +++++
 rtl/serial_word_collector.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serializer / collector pair.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WORD_W_DEFAULT = 14;

  // Width of a counter that must represent 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_word_collector_word_holding_reg.sv
// One-entry valid/ready holding buffer; flags a sticky overrun when a load
// arrives while the entry is full and not being consumed.
module word_holding_reg #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  input  logic         clr_ovr,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         overrun
);

  logic         valid_reg;
  logic [W-1:0] data_reg;
  logic         overrun_reg;
  logic         consume;

  assign consume = valid_reg & ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (load) begin
        if (!valid_reg || consume) begin
          valid_reg <= 1'b1;
          data_reg  <= load_data;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (consume) begin
        valid_reg <= 1'b0;
      end
      // Clearing wins over a same-cycle drop so the flag reads as freshly cleared.
      if (clr_ovr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign valid   = valid_reg;
  assign data    = data_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/serial_word_collector.sv
// LSB-first serial-to-parallel collector with a one-word output buffer,
// so assembly of the next word proceeds while the previous word waits.
module serial_word_collector
  import serial_pkg::*;
#(
  parameter int N     = WORD_W_DEFAULT,
  parameter int CNT_W = cnt_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             word_ready,
  output logic             word_valid,
  output logic [N-1:0]     word_out,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy,
  output logic             overrun
);

  state_t           state_reg, state_next;
  logic [N-1:0]     shift_reg, shift_next;
  logic [N-1:0]     shifted;
  logic [CNT_W-1:0] bit_count_reg, bit_count_next;
  logic             accept;
  logic             complete;

  // clear suppresses the incoming bit entirely.
  assign accept   = bit_valid & ~clear;
  assign complete = accept & (state_reg == SHIFT) & (bit_count_reg == CNT_W'(N - 1));

  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_shift
      assign shifted[gi] = shift_reg[gi+1];
    end
  endgenerate
  assign shifted[N-1] = bit_in;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_count_reg <= bit_count_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_count_next = bit_count_reg;
    if (clear) begin
      state_next     = IDLE;
      bit_count_next = '0;
    end else if (bit_valid) begin
      shift_next = shifted;
      case (state_reg)
        IDLE: begin
          state_next     = SHIFT;
          bit_count_next = CNT_W'(1);
        end
        SHIFT: begin
          if (complete) begin
            state_next     = IDLE;
            bit_count_next = '0;
          end else begin
            bit_count_next = bit_count_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next     = IDLE;
          bit_count_next = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy      = (state_reg == SHIFT);
    bit_count = bit_count_reg;
  end

  word_holding_reg #(
    .W(N)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (complete),
    .load_data (shifted),
    .ready     (word_ready),
    .clr_ovr   (clear),
    .valid     (word_valid),
    .data      (word_out),
    .overrun   (overrun)
  );

endmodule
